// File: rtl/shift_operand_sequencer.sv
// Operand-2 sequencer: decodes the shift/rotate/extend field, fetches Rs when needed,
// drives the shared shifter for one cycle and returns the result and carry over valid/ready.
module shift_operand_sequencer #(
  parameter int RS_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [11:0] op2,
  input  logic        is_imm,
  input  logic        ext_en,
  input  logic [1:0]  ext_type,
  input  logic [31:0] rm_value,
  input  logic        cin,
  output logic        rs_rd_en,
  output logic [3:0]  rs_addr,
  input  logic [31:0] rs_data,
  output logic [31:0] sh_in,
  output logic [5:0]  sh_amt,
  output logic [2:0]  sh_type,
  output logic        sh_e,
  input  logic [31:0] sh_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] result,
  output logic        carry,
  output logic        res_err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RS_READ = 3'd1;
  localparam logic [2:0] RS_WAIT = 3'd2;
  localparam logic [2:0] SHIFT   = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam logic [1:0] WAIT_INIT = 2'(RS_LAT - 1);

  localparam logic [1:0] T_LSL = 2'd0;
  localparam logic [1:0] T_LSR = 2'd1;
  localparam logic [1:0] T_ASR = 2'd2;
  localparam logic [1:0] T_ROR = 2'd3;

  logic [2:0]  state;
  logic [11:0] op2_q;
  logic        is_imm_q;
  logic        ext_en_q;
  logic [1:0]  ext_type_q;
  logic [31:0] rm_q;
  logic        cin_q;
  logic [7:0]  amt8;
  logic [1:0]  wait_cnt;

  logic        req_reg;
  logic        reg_spec;
  logic        illegal;
  logic [7:0]  n;
  logic [4:0]  n_lo;
  logic [1:0]  typ;
  logic        sign;
  logic        big;
  logic        eq32;
  logic [4:0]  lsl_idx;
  logic [4:0]  rsh_idx;
  logic [31:0] asr_mask;
  logic [31:0] res_c;
  logic        carry_c;
  logic        err_c;
  logic        rs_unused;

  assign req_reg  = !ext_en && !is_imm && op2[4] && !op2[7];
  assign reg_spec = !ext_en_q && !is_imm_q && op2_q[4] && !op2_q[7];
  assign illegal  = !ext_en_q && !is_imm_q && op2_q[4] && op2_q[7];

  assign op_ready  = (state == IDLE);
  assign res_valid = (state == DONE);
  assign rs_rd_en  = (state == RS_READ);
  assign rs_addr   = op2_q[11:8];
  assign rs_unused = ^rs_data[31:8];

  // Register-specified amounts use the whole low byte of Rs; immediate amounts are 5 bits.
  assign n        = reg_spec ? amt8 : {3'b000, op2_q[11:7]};
  assign n_lo     = n[4:0];
  assign typ      = op2_q[6:5];
  assign sign     = rm_q[31];
  assign big      = |n[7:5];
  assign eq32     = (n == 8'd32);
  assign lsl_idx  = 5'd0 - n_lo;
  assign rsh_idx  = n_lo - 5'd1;
  assign asr_mask = ~(32'hFFFF_FFFF >> n_lo);

  always_comb begin
    sh_in   = '0;
    sh_amt  = '0;
    sh_type = '0;
    sh_e    = 1'b0;
    res_c   = '0;
    carry_c = 1'b0;
    err_c   = 1'b0;
    if (state == SHIFT) begin
      if (ext_en_q) begin
        sh_e    = 1'b1;
        sh_type = {1'b0, ext_type_q};
        sh_in   = rm_q;
        res_c   = sh_result;
        carry_c = cin_q;
      end else if (is_imm_q) begin
        sh_in   = {24'b0, op2_q[7:0]};
        sh_type = {1'b0, T_ROR};
        sh_amt  = {1'b0, op2_q[11:8], 1'b0};
        res_c   = sh_result;
        carry_c = (op2_q[11:8] == 4'd0) ? cin_q : sh_result[31];
      end else if (illegal) begin
        res_c   = rm_q;
        carry_c = cin_q;
        err_c   = 1'b1;
      end else if (n == 8'd0) begin
        // Immediate-form amount 0 encodes LSR #32, ASR #32 and RRX; register amount 0 is a pass.
        if (reg_spec || typ == T_LSL) begin
          res_c   = rm_q;
          carry_c = cin_q;
        end else begin
          case (typ)
            T_LSR: begin
              res_c   = '0;
              carry_c = sign;
            end
            T_ASR: begin
              res_c   = {32{sign}};
              carry_c = sign;
            end
            default: begin
              res_c   = {cin_q, rm_q[31:1]};
              carry_c = rm_q[0];
            end
          endcase
        end
      end else begin
        case (typ)
          T_LSL: begin
            if (big) begin
              res_c   = '0;
              carry_c = eq32 ? rm_q[0] : 1'b0;
            end else begin
              sh_in   = rm_q;
              sh_type = {1'b0, T_LSL};
              sh_amt  = {1'b0, n_lo};
              res_c   = sh_result;
              carry_c = rm_q[lsl_idx];
            end
          end
          T_LSR: begin
            if (big) begin
              res_c   = '0;
              carry_c = eq32 ? sign : 1'b0;
            end else begin
              sh_in   = rm_q;
              sh_type = {1'b0, T_LSR};
              sh_amt  = {1'b0, n_lo};
              res_c   = sh_result;
              carry_c = rm_q[rsh_idx];
            end
          end
          T_ASR: begin
            if (big) begin
              res_c   = {32{sign}};
              carry_c = sign;
            end else begin
              sh_in   = rm_q;
              sh_type = {1'b0, T_ASR};
              sh_amt  = {1'b0, n_lo};
              res_c   = sh_result | (sign ? asr_mask : 32'd0);
              carry_c = rm_q[rsh_idx];
            end
          end
          default: begin
            if (n_lo == 5'd0) begin
              res_c   = rm_q;
              carry_c = sign;
            end else begin
              sh_in   = rm_q;
              sh_type = {1'b0, T_ROR};
              sh_amt  = {1'b0, n_lo};
              res_c   = sh_result;
              carry_c = sh_result[31];
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      op2_q      <= '0;
      is_imm_q   <= 1'b0;
      ext_en_q   <= 1'b0;
      ext_type_q <= '0;
      rm_q       <= '0;
      cin_q      <= 1'b0;
      amt8       <= '0;
      wait_cnt   <= '0;
      result     <= '0;
      carry      <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            op2_q      <= op2;
            is_imm_q   <= is_imm;
            ext_en_q   <= ext_en;
            ext_type_q <= ext_type;
            rm_q       <= rm_value;
            cin_q      <= cin;
            state      <= req_reg ? RS_READ : SHIFT;
          end
        end
        RS_READ: begin
          wait_cnt <= WAIT_INIT;
          state    <= RS_WAIT;
        end
        RS_WAIT: begin
          if (wait_cnt == 2'd0) begin
            amt8  <= rs_data[7:0];
            state <= SHIFT;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        SHIFT: begin
          result  <= res_c;
          carry   <= carry_c;
          res_err <= err_c;
          state   <= DONE;
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_operand_sequencer.sv
// Directed bench for shift_operand_sequencer: vector table plus backpressure and reset-abort sequences.
module tb_shift_operand_sequencer;
  localparam int RS_LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid;
  logic        op_ready;
  logic [11:0] op2;
  logic        is_imm;
  logic        ext_en;
  logic [1:0]  ext_type;
  logic [31:0] rm_value;
  logic        cin;
  logic        rs_rd_en;
  logic [3:0]  rs_addr;
  logic [31:0] rs_data;
  logic [31:0] sh_in;
  logic [5:0]  sh_amt;
  logic [2:0]  sh_type;
  logic        sh_e;
  logic [31:0] sh_result;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] result;
  logic        carry;
  logic        res_err;

  always #5 clk = ~clk;

  shift_operand_sequencer #(.RS_LAT(RS_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
    .op2(op2), .is_imm(is_imm), .ext_en(ext_en), .ext_type(ext_type),
    .rm_value(rm_value), .cin(cin), .rs_rd_en(rs_rd_en), .rs_addr(rs_addr),
    .rs_data(rs_data), .sh_in(sh_in), .sh_amt(sh_amt), .sh_type(sh_type),
    .sh_e(sh_e), .sh_result(sh_result), .res_valid(res_valid),
    .res_ready(res_ready), .result(result), .carry(carry), .res_err(res_err)
  );

  // Register file: data is only valid exactly RS_LAT cycles after the strobe.
  logic [RS_LAT-1:0] rd_pipe = '0;
  logic [31:0]       rs_val = '0;
  always @(posedge clk) rd_pipe <= {rd_pipe[RS_LAT-2:0], rs_rd_en};
  assign rs_data = rd_pipe[RS_LAT-1] ? rs_val : 32'hDEAD_BEEF;

  // Shifter model; ASR is deliberately logical so the block must supply the sign fill.
  logic [31:0] sh_model;
  always_comb begin
    sh_model = '0;
    if (sh_e) begin
      case (sh_type[1:0])
        2'd0: sh_model = {{24{sh_in[7]}}, sh_in[7:0]};
        2'd1: sh_model = {24'd0, sh_in[7:0]};
        2'd2: sh_model = {{16{sh_in[15]}}, sh_in[15:0]};
        default: sh_model = {16'd0, sh_in[15:0]};
      endcase
    end else begin
      case (sh_type)
        3'd0: sh_model = sh_in << sh_amt;
        3'd1: sh_model = sh_in >> sh_amt;
        3'd2: sh_model = sh_in >> sh_amt;
        3'd3: sh_model = (sh_amt[4:0] == 5'd0) ? sh_in :
                         ((sh_in >> sh_amt[4:0]) | (sh_in << (6'd32 - {1'b0, sh_amt[4:0]})));
        default: sh_model = '0;
      endcase
    end
  end
  assign sh_result = sh_model;

  typedef struct {
    logic [11:0] op2;
    logic        is_imm;
    logic        ext_en;
    logic [1:0]  ext_type;
    logic [31:0] rm;
    logic        cin;
    logic [31:0] rs;
    logic [31:0] exp_res;
    logic        exp_c;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
  } vec_t;

  vec_t vq[$];
  int passed = 0;
  int total  = 0;

  int          o_lat, o_rd;
  logic [3:0]  o_addr;
  logic [5:0]  o_amt;
  logic [2:0]  o_type;
  logic        o_e;
  logic [31:0] o_res;
  logic        o_c, o_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic add(input logic [11:0] o, input logic im, input logic ex, input logic [1:0] et,
                     input logic [31:0] rm, input logic ci, input logic [31:0] rs,
                     input logic [31:0] er, input logic ec, input logic ee, input int el, input int ed);
    vec_t v;
    v.op2 = o; v.is_imm = im; v.ext_en = ex; v.ext_type = et; v.rm = rm; v.cin = ci; v.rs = rs;
    v.exp_res = er; v.exp_c = ec; v.exp_err = ee; v.exp_lat = el; v.exp_rd = ed;
    vq.push_back(v);
  endtask

  // Issues one request, scrambles the inputs after accept, and records what the DUT did.
  task automatic run_op(input vec_t v);
    @(negedge clk);
    op2 = v.op2; is_imm = v.is_imm; ext_en = v.ext_en; ext_type = v.ext_type;
    rm_value = v.rm; cin = v.cin; rs_val = v.rs; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op2 = 12'($urandom); rm_value = $urandom; cin = ~v.cin;
    is_imm = ~v.is_imm; ext_en = ~v.ext_en; ext_type = ~v.ext_type;
    o_lat = 0; o_rd = 0; o_addr = '0; o_amt = '0; o_type = '0; o_e = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rs_rd_en) begin
        o_rd++;
        o_addr = rs_addr;
      end
      if (res_valid) begin
        o_lat = c;
        break;
      end
      o_amt = sh_amt; o_type = sh_type; o_e = sh_e;
    end
    o_res = result; o_c = carry; o_err = res_err;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    int   cnt;
    reset_n = 1'b0; op_valid = 1'b0; res_ready = 1'b1;
    op2 = '0; is_imm = 1'b0; ext_en = 1'b0; ext_type = '0; rm_value = '0; cin = 1'b0;

    // Immediate forms
    add(12'h4FF, 1, 0, 0, 32'h0, 0, 0, 32'hFF00_0000, 1, 0, 2, 0);
    add(12'h0AB, 1, 0, 0, 32'h0, 1, 0, 32'h0000_00AB, 1, 0, 2, 0);
    // Immediate-amount register shifts
    add(12'h020, 0, 0, 0, 32'h8000_0001, 0, 0, 32'h0000_0000, 1, 0, 2, 0);
    add(12'h060, 0, 0, 0, 32'h8000_0001, 1, 0, 32'hC000_0000, 1, 0, 2, 0);
    add(12'h000, 0, 0, 0, 32'h8000_0001, 0, 0, 32'h8000_0001, 0, 0, 2, 0);
    add(12'h040, 0, 0, 0, 32'h8000_0001, 0, 0, 32'hFFFF_FFFF, 1, 0, 2, 0);
    add(12'h200, 0, 0, 0, 32'h1234_5678, 0, 0, 32'h2345_6780, 1, 0, 2, 0);
    add(12'h240, 0, 0, 0, 32'h8000_0018, 0, 0, 32'hF800_0001, 1, 0, 2, 0);
    add(12'h0A0, 0, 0, 0, 32'h0000_0003, 0, 0, 32'h0000_0001, 1, 0, 2, 0);
    add(12'h460, 0, 0, 0, 32'h0000_00AB, 0, 0, 32'hAB00_0000, 1, 0, 2, 0);
    // Register-specified shifts
    add(12'h310, 0, 0, 0, 32'hFFFF_FFFF, 1, 33,  32'h0000_0000, 0, 0, 3 + RS_LAT, 1);
    add(12'h350, 0, 0, 0, 32'h8000_0000, 0, 32,  32'hFFFF_FFFF, 1, 0, 3 + RS_LAT, 1);
    add(12'h310, 0, 0, 0, 32'h0000_0001, 0, 32,  32'h0000_0000, 1, 0, 3 + RS_LAT, 1);
    add(12'h530, 0, 0, 0, 32'h8000_0000, 0, 32,  32'h0000_0000, 1, 0, 3 + RS_LAT, 1);
    add(12'h930, 0, 0, 0, 32'hFFFF_FFFF, 1, 40,  32'h0000_0000, 0, 0, 3 + RS_LAT, 1);
    add(12'h370, 0, 0, 0, 32'h1234_5678, 1, 0,   32'h1234_5678, 1, 0, 3 + RS_LAT, 1);
    add(12'h770, 0, 0, 0, 32'h8000_0001, 0, 32,  32'h8000_0001, 1, 0, 3 + RS_LAT, 1);
    add(12'hA70, 0, 0, 0, 32'h0000_00AB, 0, 32'h108, 32'hAB00_0000, 1, 0, 3 + RS_LAT, 1);
    add(12'h310, 0, 0, 0, 32'h1234_5678, 0, 4,   32'h2345_6780, 1, 0, 3 + RS_LAT, 1);
    add(12'h350, 0, 0, 0, 32'h8000_0018, 0, 4,   32'hF800_0001, 1, 0, 3 + RS_LAT, 1);
    // Extend and illegal
    add(12'h000, 0, 1, 0, 32'h0000_0080, 1, 0, 32'hFFFF_FF80, 1, 0, 2, 0);
    add(12'h000, 0, 1, 3, 32'hABCD_8765, 0, 0, 32'h0000_8765, 0, 0, 2, 0);
    add(12'h090, 0, 0, 0, 32'hCAFE_F00D, 1, 0, 32'hCAFE_F00D, 1, 1, 2, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_rs_rd_en", 32'(rs_rd_en), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_carry_err", {30'd0, carry, res_err}, 32'd0);
    chk("rst_sh", {sh_in[31:22] | sh_in[21:0], sh_amt, sh_type, sh_e}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      run_op(v);
      chk($sformatf("v%0d_latency", i), 32'(o_lat), 32'(v.exp_lat));
      chk($sformatf("v%0d_result", i), o_res, v.exp_res);
      chk($sformatf("v%0d_carry", i), 32'(o_c), 32'(v.exp_c));
      chk($sformatf("v%0d_err", i), 32'(o_err), 32'(v.exp_err));
      chk($sformatf("v%0d_rd_count", i), 32'(o_rd), 32'(v.exp_rd));
      if (v.exp_rd != 0) chk($sformatf("v%0d_rs_addr", i), 32'(o_addr), 32'(v.op2[11:8]));
      if (v.is_imm) begin
        chk($sformatf("v%0d_sh_amt", i), 32'(o_amt), 32'({v.op2[11:8], 1'b0}));
        chk($sformatf("v%0d_sh_type", i), 32'(o_type), 32'd3);
      end
      if (v.ext_en) begin
        chk($sformatf("v%0d_sh_e", i), 32'(o_e), 32'd1);
        chk($sformatf("v%0d_sh_type", i), 32'(o_type), 32'({1'b0, v.ext_type}));
      end
      $display("vec %0d op2=%03h imm=%0d ext=%0d rm=%08h -> result=%08h carry=%0d err=%0d lat=%0d",
               i, v.op2, v.is_imm, v.ext_en, v.rm, o_res, o_c, o_err, o_lat);
    end

    // Backpressure: result held, no accept while DONE
    res_ready = 1'b0;
    @(negedge clk);
    op2 = 12'h4FF; is_imm = 1'b1; ext_en = 1'b0; cin = 1'b0; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op2 = 12'h0AB; cin = 1'b1;
    cnt = 0;
    while (!res_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("bp_valid_seen", 32'(res_valid), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_result", c), result, 32'hFF00_0000);
      chk($sformatf("bp_hold%0d_op_ready", c), 32'(op_ready), 32'd0);
      chk($sformatf("bp_hold%0d_valid", c), 32'(res_valid), 32'd1);
    end
    op_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_op_ready", 32'(op_ready), 32'd1);
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (res_valid) cnt++;
    end
    chk("bp_no_extra_valid", 32'(cnt), 32'd0);
    $display("backpressure sequence done: held result=%08h", 32'hFF00_0000);

    // Reset abort during RS_WAIT
    @(negedge clk);
    op2 = 12'h310; is_imm = 1'b0; ext_en = 1'b0; rm_value = 32'hFFFF_FFFF; rs_val = 33; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    @(negedge clk);
    chk("abort_rs_read", 32'(rs_rd_en), 32'd1);
    @(negedge clk);
    chk("abort_in_wait", 32'(op_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("abort_op_ready", 32'(op_ready), 32'd1);
    chk("abort_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (res_valid) cnt++;
    end
    chk("abort_no_valid", 32'(cnt), 32'd0);
    $display("reset-abort sequence done");

    // Recovery after abort
    v = vq[0];
    run_op(v);
    chk("recover_result", o_res, v.exp_res);
    chk("recover_latency", 32'(o_lat), 32'(v.exp_lat));
    $display("recovery op result=%08h lat=%0d", o_res, o_lat);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/shift_operand_sequencer.md
Name: shift_operand_sequencer

Overview:
- Sequences the shared shifter/extender datapath for data-processing operand 2.
- Accepts one operand request, decodes the 12-bit operand-2 field (or an extend request), and fetches Rs from the register file when the shift amount is register-specified.
- Drives the shifter for one cycle, handles the amount-0 and amount-≥32 cases by bypassing the shifter, and computes the carry-out itself.
- Returns result and carry over a valid/ready handshake.

Parameters:
RS_LAT, 1, register-file read latency in cycles from rs_rd_en to valid rs_data (legal 1..3)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
op_valid  in  1  operand request valid
op_ready  out  1  high only in IDLE
op2  in  12  operand-2 field, instruction bits [11:0]
is_imm  in  1  I bit: 1 = rotated 8-bit immediate
ext_en  in  1  extend request: drive shifter with E=1
ext_type  in  2  extend type: 0 sxtb, 1 uxtb, 2 sxth, 3 uxth
rm_value  in  32  Rm value
cin  in  1  current C flag
rs_rd_en  out  1  register-file read strobe (one cycle)
rs_addr  out  4  Rs index = op2[11:8]
rs_data  in  32  Rs value, valid RS_LAT cycles after rs_rd_en
sh_in  out  32  shifter data input
sh_amt  out  6  shifter amount
sh_type  out  3  0 LSL, 1 LSR, 2 ASR, 3 ROR
sh_e  out  1  shifter extend select
sh_result  in  32  shifter combinational output
res_valid  out  1  result valid
res_ready  in  1  consumer ready
result  out  32  operand-2 value
carry  out  1  shifter carry-out
res_err  out  1  illegal encoding flag, qualified by res_valid

Behaviour:
- States: IDLE, RS_READ, RS_WAIT, SHIFT, DONE.
- Reset (asynchronous): state IDLE. op_ready=1. rs_rd_en, res_valid, res_err, carry = 0. result = 0. All sh_* = 0. A reset mid-operation aborts the operation; no res_valid is produced.
- Accept on op_valid & op_ready. On accept, latch op2, is_imm, ext_en, ext_type, rm_value and cin; later changes to these inputs are ignored.
- IDLE → RS_READ when the request is register-specified (!ext_en & !is_imm & op2[4] & !op2[7]). Otherwise IDLE → SHIFT.
- RS_READ: one cycle, rs_rd_en=1, rs_addr=op2[11:8]. Then → RS_WAIT.
- RS_WAIT: lasts RS_LAT cycles, counted by a down-counter. Latch rs_data[7:0] as amt8 in the final cycle. Then → SHIFT.
- SHIFT: one cycle. sh_* are driven only in this state and are 0 in all other states. Register result/carry/res_err at the end of SHIFT, then → DONE.
- DONE: res_valid=1; result, carry and res_err are held stable. → IDLE when res_ready.
- Latency from the accept edge to res_valid: 2 cycles for immediate/extend requests, 3+RS_LAT cycles for register-specified requests. Minimum request spacing is 3 cycles.
- Extend (ext_en=1, highest priority): sh_e=1, sh_type={0,ext_type}, sh_amt=0, sh_in=Rm. result=sh_result, carry=cin.
- Immediate: sh_in={24'b0, op2[7:0]}, type ROR, sh_amt=2*op2[11:8]. result=sh_result. carry=cin if amount is 0, else sh_result[31].
- Immediate-amount register shift (op2[4]=0): n=op2[11:7], type=op2[6:5].
  - n=0, LSL: result=Rm, carry=cin.
  - n=0, LSR: bypass. result=0, carry=Rm[31].
  - n=0, ASR: bypass. result={32{Rm[31]}}, carry=Rm[31].
  - n=0, ROR (RRX): bypass. result={cin, Rm[31:1]}, carry=Rm[0].
- Register-specified shift: n=amt8, type=op2[6:5].
  - n=0: result=Rm, carry=cin.
  - LSL n=32: result 0, carry Rm[0]. LSL n>32: result 0, carry 0.
  - LSR n=32: result 0, carry Rm[31]. LSR n>32: result 0, carry 0.
  - ASR n≥32: result sign-fill, carry Rm[31].
  - ROR with n[4:0]=0 and n≠0: result=Rm, carry=Rm[31]. Otherwise ROR by n[4:0].
- In-range shifts use the shifter (sh_e=0, sh_in=Rm, sh_amt=n). Carry rules:
  - LSL: Rm[32-n].
  - LSR, ASR: Rm[n-1].
  - ASR result = sh_result OR'd with sign mask when Rm[31]=1; the block does not rely on shifter sign fill.
  - ROR: result[31].
- Illegal encoding (!is_imm, op2[4]=1, op2[7]=1): skip RS_READ and go to SHIFT. result=Rm, carry=cin, res_err=1.

Test Plan:
1. Immediate: is_imm=1, op2=0x4FF (rot 4, amount 8) → sh_amt=8, sh_type=3; result=0xFF000000, carry=1, res_valid 2 cycles after accept.
2. Immediate shift: Rm=0x80000001, LSR #0 → result=0, carry=1; ROR #0 with cin=1 → result=0xC0000000, carry=1; LSL #0 with cin=0 → result=Rm, carry=0.
3. Register shift with RS_LAT=2: Rs data=33, LSL, Rm=0xFFFFFFFF → rs_rd_en one cycle, res_valid 5 cycles after accept, result=0, carry=0. Rs=32 ASR, Rm=0x80000000 → result=0xFFFFFFFF, carry=1.
4. Extend: ext_en=1, ext_type=0, Rm=0x00000080, cin=1 → sh_e=1; result equals sh_result; carry=1; latency 2 cycles.
5. Backpressure and reset: hold res_ready=0 for 4 cycles → result stable, op_ready=0, new op_valid ignored. Separately, assert reset_n=0 in RS_WAIT → IDLE immediately, no res_valid.
6. Illegal: op2[7]=1, op2[4]=1, is_imm=0 → rs_rd_en never asserted; res_err=1, result=Rm.
